// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Moore-style sequencer for a multicycle RV32I datapath. Walks each
// instruction through FETCH, DECODE, EXECUTE and WRITEBACK, stalling on the
// memory ready handshake in FETCH, MEMREAD and MEMWRITE.
//
// Parameters:
//   DATA_WIDTH     instruction width (>= 32)
//   IMM_SRC_WIDTH  width of ImmSrc
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   Instr           instruction register contents
//   Zero            ALU zero flag
//   MemReady        memory completed the current access this cycle
//   PCWrite         PC register enable
//   AdrSrc          memory address select (0 = PC, 1 = ALUOut)
//   MemWrite        memory write request
//   IRWrite         IR / OldPC enable
//   RegWrite        register file write enable
//   ResultSrc       result select (00 ALUOut, 01 Data, 10 ALUResult)
//   ALUSrcA         ALU A select (00 PC, 01 OldPC, 10 RD1)
//   ALUSrcB         ALU B select (00 RD2, 01 ImmExt, 10 constant 4)
//   ImmSrc          immediate format (00 I, 01 S, 10 B)
//   ALUControl      ALU op (000 add, 001 sub, 010 and, 011 or, 101 slt)
//   IllegalInstr    one-cycle pulse in DECODE for an unsupported encoding
//   State           current state encoding (debug)
//
// Configuration macro:
//   CTRL_BNE_EN  when defined, bne (funct3 = 001) is a legal branch that
//                loads the PC when Zero is clear. When undefined, every
//                branch other than beq is reported as illegal.
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int DATA_WIDTH    = 32,
    parameter int IMM_SRC_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    Instr,
    input  logic                     Zero,
    input  logic                     MemReady,
    output logic                     PCWrite,
    output logic                     AdrSrc,
    output logic                     MemWrite,
    output logic                     IRWrite,
    output logic                     RegWrite,
    output logic [1:0]               ResultSrc,
    output logic [1:0]               ALUSrcA,
    output logic [1:0]               ALUSrcB,
    output logic [IMM_SRC_WIDTH-1:0] ImmSrc,
    output logic [2:0]               ALUControl,
    output logic                     IllegalInstr,
    output logic [3:0]               State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_e;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Immediate format from the opcode alone; valid in every state.
    function automatic logic [IMM_SRC_WIDTH-1:0] imm_decode(input logic [6:0] op);
        logic [IMM_SRC_WIDTH-1:0] r;
        case (op)
            OP_SW:     r = IMM_SRC_WIDTH'(2'b01);
            OP_BRANCH: r = IMM_SRC_WIDTH'(2'b10);
            default:   r = IMM_SRC_WIDTH'(2'b00);
        endcase
        return r;
    endfunction

    // ALU operation for register and immediate arithmetic. Instr[5]
    // separates R-type from I-type so that addi with imm[10] set stays add.
    function automatic logic [2:0] alu_decode(input logic [2:0] f3,
                                              input logic op5,
                                              input logic f7b5);
        logic [2:0] r;
        case (f3)
            3'b000: begin
                if (op5 && f7b5) begin
                    r = 3'b001;
                end else begin
                    r = 3'b000;
                end
            end
            3'b010:  r = 3'b101;
            3'b110:  r = 3'b011;
            3'b111:  r = 3'b010;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    // Which branch conditions this build supports.
    function automatic logic branch_legal(input logic [2:0] f3);
        logic r;
        case (f3)
            3'b000:  r = 1'b1;
`ifdef CTRL_BNE_EN
            3'b001:  r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Branch decision from funct3 and the subtraction zero flag.
    function automatic logic branch_taken(input logic [2:0] f3, input logic z);
        logic r;
        case (f3)
            3'b000:  r = z;
`ifdef CTRL_BNE_EN
            3'b001:  r = ~z;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    state_e     state_q;
    state_e     state_d;
    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic       pc_write_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic       illegal_s;
    logic       adr_src_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [2:0] alu_control_s;
    logic       unused_instr_s;

    assign opcode_s       = Instr[6:0];
    assign funct3_s       = Instr[14:12];
    assign unused_instr_s = ^{Instr[DATA_WIDTH-1:31], Instr[29:15], Instr[11:7]};

    // State register; reset returns to FETCH and aborts any instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state output decode.
    always_comb begin
        state_d       = S_FETCH;
        pc_write_s    = 1'b0;
        mem_write_s   = 1'b0;
        ir_write_s    = 1'b0;
        reg_write_s   = 1'b0;
        illegal_s     = 1'b0;
        adr_src_s     = 1'b0;
        result_src_s  = 2'b00;
        alu_src_a_s   = 2'b00;
        alu_src_b_s   = 2'b00;
        alu_control_s = 3'b000;
        case (state_q)
            S_FETCH: begin
                // PC + 4 is computed while the instruction is read.
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                ir_write_s   = MemReady;
                pc_write_s   = MemReady;
                if (MemReady) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // OldPC + imm precomputes the branch target into ALUOut.
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                case (opcode_s)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_BRANCH: begin
                        if (branch_legal(funct3_s)) begin
                            state_d = S_BRANCH;
                        end else begin
                            state_d   = S_FETCH;
                            illegal_s = 1'b1;
                        end
                    end
                    default: begin
                        state_d   = S_FETCH;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                if (opcode_s == OP_SW) begin
                    state_d = S_MEMWRITE;
                end else if (opcode_s == OP_LW) begin
                    state_d = S_MEMREAD;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMREAD: begin
                adr_src_s = 1'b1;
                if (MemReady) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
                if (MemReady) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_EXECUTER: begin
                alu_src_a_s   = 2'b10;
                alu_control_s = alu_decode(funct3_s, Instr[5], Instr[30]);
                state_d       = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a_s   = 2'b10;
                alu_src_b_s   = 2'b01;
                alu_control_s = alu_decode(funct3_s, Instr[5], Instr[30]);
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_s   = 2'b10;
                alu_control_s = 3'b001;
                pc_write_s    = branch_taken(funct3_s, Zero);
                state_d       = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Strobes are gated by reset so no write escapes while rst_n is low;
    // selects already show FETCH values because the state is held there.
    assign PCWrite      = rst_n & pc_write_s;
    assign MemWrite     = rst_n & mem_write_s;
    assign IRWrite      = rst_n & ir_write_s;
    assign RegWrite     = rst_n & reg_write_s;
    assign IllegalInstr = rst_n & illegal_s;
    assign AdrSrc       = adr_src_s;
    assign ResultSrc    = result_src_s;
    assign ALUSrcA      = alu_src_a_s;
    assign ALUSrcB      = alu_src_b_s;
    assign ALUControl   = alu_control_s;
    assign ImmSrc       = imm_decode(opcode_s);
    assign State        = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// Testbench for multicycle_control. Each instruction is expanded into the
// list of cycles it must occupy (stalls included) from its class; a per-state
// output table plus the instruction's dynamic rules gives the expected
// outputs for every cycle, which a single negedge process compares.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] imm;
        logic [2:0] alu;
        logic       ill;
    } exp_t;

`ifdef CTRL_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] Instr;
    logic        Zero;
    logic        MemReady;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]  ALUControl;
    logic [3:0]  State;

    int   n_pass = 0;
    int   n_tot  = 0;
    bit   chk_en = 1'b0;
    exp_t exp_r;
    exp_t base [10];
    int   st_log[$];
    logic [2:0] last_alu;
    logic       last_br_pcw;
    logic [1:0] last_br_imm;
    logic       last_ill;

    multicycle_control #(.DATA_WIDTH(32), .IMM_SRC_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .Instr(Instr), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .IllegalInstr(IllegalInstr), .State(State)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_tot++;
        if (act === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    // Instruction class: 0 lw, 1 sw, 2 R, 3 I, 4 legal branch, 5 illegal
    function automatic int cls_of(input logic [31:0] ins);
        logic [2:0] f3;
        f3 = ins[14:12];
        case (ins[6:0])
            7'h03: return 0;
            7'h23: return 1;
            7'h33: return 2;
            7'h13: return 3;
            7'h63: return ((f3 == 3'd0) || (BNE_EN && f3 == 3'd1)) ? 4 : 5;
            default: return 5;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [31:0] ins);
        case (ins[14:12])
            3'b000:  return (ins[5] && ins[30]) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected outputs for one cycle: static table row plus dynamic strobes.
    function automatic exp_t model_row(input int st, input logic mr, input logic z,
                                       input logic [31:0] ins);
        exp_t r;
        r     = base[st];
        r.st  = 4'(st);
        r.imm = (ins[6:0] == 7'h23) ? 2'b01 : ((ins[6:0] == 7'h63) ? 2'b10 : 2'b00);
        if (st == 0) begin
            r.pcw = mr;
            r.irw = mr;
        end
        if (st == 1) r.ill = (cls_of(ins) == 5);
        if (st == 5) r.mw = 1'b1;
        if (st == 4 || st == 8) r.rw = 1'b1;
        if (st == 6 || st == 7) r.alu = alu_of(ins);
        if (st == 9) begin
            if (ins[14:12] == 3'd0) r.pcw = z;
            else if (BNE_EN && ins[14:12] == 3'd1) r.pcw = ~z;
            else r.pcw = 1'b0;
        end
        return r;
    endfunction

    // Single compare process, sampling on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("State", 32'(State), 32'(exp_r.st));
            chk("PCWrite", 32'(PCWrite), 32'(exp_r.pcw));
            chk("AdrSrc", 32'(AdrSrc), 32'(exp_r.adr));
            chk("MemWrite", 32'(MemWrite), 32'(exp_r.mw));
            chk("IRWrite", 32'(IRWrite), 32'(exp_r.irw));
            chk("RegWrite", 32'(RegWrite), 32'(exp_r.rw));
            chk("ResultSrc", 32'(ResultSrc), 32'(exp_r.res));
            chk("ALUSrcA", 32'(ALUSrcA), 32'(exp_r.sa));
            chk("ALUSrcB", 32'(ALUSrcB), 32'(exp_r.sb));
            chk("ImmSrc", 32'(ImmSrc), 32'(exp_r.imm));
            chk("ALUControl", 32'(ALUControl), 32'(exp_r.alu));
            chk("IllegalInstr", 32'(IllegalInstr), 32'(exp_r.ill));
            st_log.push_back(int'(State));
            if (State == 4'd6 || State == 4'd7) last_alu = ALUControl;
            if (State == 4'd9) begin
                last_br_pcw = PCWrite;
                last_br_imm = ImmSrc;
            end
            if (IllegalInstr) last_ill = 1'b1;
        end
    end

    task automatic step(input int st, input logic mr, input logic z, input logic [31:0] ins);
        Instr    = ins;
        MemReady = mr;
        Zero     = z;
        exp_r    = model_row(st, mr, z, ins);
        chk_en   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Expand an instruction into its cycle list and step through it.
    task automatic run_instr(input logic [31:0] ins, input int fst, input int mst,
                             input logic z);
        int   path[$];
        logic mrq[$];
        int   c;
        c = cls_of(ins);
        for (int i = 0; i <= fst; i++) begin path.push_back(0); mrq.push_back(i == fst); end
        path.push_back(1); mrq.push_back(1'b1);
        case (c)
            0: begin
                path.push_back(2); mrq.push_back(1'b1);
                for (int i = 0; i <= mst; i++) begin path.push_back(3); mrq.push_back(i == mst); end
                path.push_back(4); mrq.push_back(1'b1);
            end
            1: begin
                path.push_back(2); mrq.push_back(1'b1);
                for (int i = 0; i <= mst; i++) begin path.push_back(5); mrq.push_back(i == mst); end
            end
            2: begin path.push_back(6); mrq.push_back(1'b1); path.push_back(8); mrq.push_back(1'b1); end
            3: begin path.push_back(7); mrq.push_back(1'b1); path.push_back(8); mrq.push_back(1'b1); end
            4: begin path.push_back(9); mrq.push_back(1'b1); end
            default: ;
        endcase
        st_log.delete();
        last_ill    = 1'b0;
        last_alu    = 3'b111;
        last_br_pcw = 1'bx;
        last_br_imm = 2'bxx;
        foreach (path[k]) step(path[k], mrq[k], z, ins);
        chk("ret_fetch", 32'(State), 32'd0);
    endtask

    task automatic chk_seq(input string nm, input int want[$]);
        chk({nm, "_len"}, 32'(st_log.size()), 32'(want.size()));
        foreach (want[k]) begin
            if (k < st_log.size()) chk(nm, 32'(st_log[k]), 32'(want[k]));
        end
    endtask

    initial begin
        int q[$];
        // Static per-state table: AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl.
        for (int i = 0; i < 10; i++) base[i] = '0;
        base[0].sb = 2'b10; base[0].res = 2'b10;
        base[1].sa = 2'b01; base[1].sb = 2'b01;
        base[2].sa = 2'b10; base[2].sb = 2'b01;
        base[3].adr = 1'b1;
        base[4].res = 2'b01;
        base[5].adr = 1'b1;
        base[6].sa = 2'b10;
        base[7].sa = 2'b10; base[7].sb = 2'b01;
        base[9].sa = 2'b10; base[9].alu = 3'b001;

        rst_n = 1'b0; Instr = 32'h00412083; MemReady = 1'b1; Zero = 1'b0;
        @(posedge clk); #1;
        // Reset: MemReady high must not leak through as IRWrite/PCWrite.
        for (int i = 0; i < 2; i++) begin
            exp_r  = model_row(0, 1'b0, 1'b0, Instr);
            chk_en = 1'b1;
            @(posedge clk); #1;
        end
        chk("rst_ALUSrcB", 32'(ALUSrcB), 32'h2);
        chk("rst_IRWrite", 32'(IRWrite), 32'h0);
        rst_n = 1'b1;

        // lw with 2 fetch stalls and 3 read stalls.
        run_instr(32'h00412083, 2, 3, 1'b0);
        q = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4};
        chk_seq("lw_stall_seq", q);
        run_instr(32'h00412083, 0, 0, 1'b0);
        q = '{0, 1, 2, 3, 4};
        chk_seq("lw_seq", q);

        // sw, with and without write stalls.
        run_instr(32'h00112223, 0, 0, 1'b0);
        q = '{0, 1, 2, 5};
        chk_seq("sw_seq", q);
        run_instr(32'h00112223, 1, 2, 1'b1);

        // R-type and I-type function decode.
        run_instr(32'h40208033, 0, 0, 1'b0);
        q = '{0, 1, 6, 8};
        chk_seq("r_seq", q);
        chk("sub_alu", 32'(last_alu), 32'h1);
        run_instr(32'h0020A033, 0, 0, 1'b0);
        chk("slt_alu", 32'(last_alu), 32'h5);
        run_instr(32'h0020F033, 0, 0, 1'b0);
        chk("and_alu", 32'(last_alu), 32'h2);
        run_instr(32'h0020E033, 0, 0, 1'b0);
        chk("or_alu", 32'(last_alu), 32'h3);
        run_instr(32'h00208033, 0, 0, 1'b0);
        chk("add_alu", 32'(last_alu), 32'h0);
        run_instr(32'h40010093, 0, 0, 1'b0);
        q = '{0, 1, 7, 8};
        chk_seq("i_seq", q);
        chk("addi_bit30_alu", 32'(last_alu), 32'h0);
        run_instr(32'h40115093, 0, 0, 1'b0);
        chk("i_f3_101_alu", 32'(last_alu), 32'h0);

        // beq taken / not taken.
        run_instr(32'h00208463, 0, 0, 1'b1);
        q = '{0, 1, 9};
        chk_seq("beq_seq", q);
        chk("beq_taken_pcw", 32'(last_br_pcw), 32'h1);
        chk("beq_imm", 32'(last_br_imm), 32'h2);
        run_instr(32'h00208463, 0, 0, 1'b0);
        chk("beq_not_taken_pcw", 32'(last_br_pcw), 32'h0);

        // Illegal opcode, bne, blt.
        run_instr(32'h0000007F, 0, 0, 1'b0);
        q = '{0, 1};
        chk_seq("illegal_seq", q);
        chk("illegal_pulse", 32'(last_ill), 32'h1);
        run_instr(32'h00209463, 0, 0, 1'b0);
        chk("bne_illegal", 32'(last_ill), BNE_EN ? 32'h0 : 32'h1);
        run_instr(32'h00209463, 0, 0, 1'b1);
        run_instr(32'h0020C463, 0, 0, 1'b1);
        chk("blt_illegal", 32'(last_ill), 32'h1);

        // Reset mid-lw (stalled in MEMREAD) aborts with no writes.
        step(0, 1'b1, 1'b0, 32'h00412083);
        step(1, 1'b1, 1'b0, 32'h00412083);
        step(2, 1'b1, 1'b0, 32'h00412083);
        step(3, 1'b0, 1'b0, 32'h00412083);
        rst_n    = 1'b0;
        MemReady = 1'b1;
        exp_r    = model_row(0, 1'b0, 1'b0, 32'h00412083);
        @(posedge clk); #1;
        chk("abort_state", 32'(State), 32'h0);
        chk("abort_regwrite", 32'(RegWrite), 32'h0);
        rst_n = 1'b1;
        run_instr(32'h0020A013, 0, 0, 1'b0);
        chk("slti_alu", 32'(last_alu), 32'h5);

        chk_en = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
